adder_seq_ctrl: RTL and testbench

- Sequencer that performs multi-precision add/subtract of two NUM_WORDS x 16-bit operands.
- Time-shares a single internal adder_16bit instance, one word per clock, least-significant word first.
- Carry is chained between words through a carry register.
- Sits between a requesting controller (start/done handshake) and the shared 16-bit adder datapath.

---
 rtl/adder_seq_ctrl.sv | 93 +++++++++
 tb/tb_adder_seq_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: multi-precision add/subtract sequencer driving one shared 16-bit adder, LSW first
// Ports: clk, rst (sync, active-high); start, sub, op_a, op_b request inputs;
//        busy, done, result, carry_out, overflow registered status/result outputs.
module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carry_in,
    output logic [15:0] sum,
    output logic        overflow
);
    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {16'b0, carry_in};
endmodule

module adder_seq_ctrl #(
    parameter int NUM_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    sub,
    input  logic [16*NUM_WORDS-1:0] op_a,
    input  logic [16*NUM_WORDS-1:0] op_b,
    output logic                    busy,
    output logic                    done,
    output logic [16*NUM_WORDS-1:0] result,
    output logic                    carry_out,
    output logic                    overflow
);
    localparam int W  = 16 * NUM_WORDS;
    localparam int IW = $clog2(NUM_WORDS);
    localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t        state;
    logic [W-1:0]  a_q, b_q;
    logic [IW-1:0] idx;
    logic          cy;
    logic [15:0]   w_sum;
    logic          w_cy;
    adder_16bit u_add (
        .a        (a_q[{idx, 4'b0000} +: 16]),
        .b        (b_q[{idx, 4'b0000} +: 16]),
        .carry_in (cy),
        .sum      (w_sum),
        .overflow (w_cy)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            result    <= '0;
            idx       <= '0;
            cy        <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= ADD;
                        busy   <= 1'b1;
                        a_q    <= op_a;
                        // subtraction is A + ~B + 1: invert here, seed the carry with sub
                        b_q    <= sub ? ~op_b : op_b;
                        cy     <= sub;
                        idx    <= '0;
                        result <= '0;
                    end
                end
                ADD: begin
                    result[{idx, 4'b0000} +: 16] <= w_sum;
                    cy  <= w_cy;
                    idx <= idx + 1'b1;
                    if (idx == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        carry_out <= w_cy;
                        overflow  <= (a_q[W-1] == b_q[W-1]) && (w_sum[15] != a_q[W-1]);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed-vector bench for adder_seq_ctrl with NUM_WORDS=4
module tb_adder_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, sub;
    logic [63:0] op_a, op_b;
    logic        busy, done, carry_out, overflow;
    logic [63:0] result;
    int          vectors = 0;
    int          errors = 0;

    adder_seq_ctrl #(.NUM_WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after done.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b, input logic s,
                          input bit mid_pulse, input logic [63:0] er, input logic ec, input logic eo);
        int busy_n = 0;
        int done_at = 0;
        int done_n = 0;
        op_a = a; op_b = b; sub = s; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 20 && done_at == 0; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (mid_pulse && n == 2) begin
                start = 1'b1; op_a = '1; op_b = '1;
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = n;
            end
        end
        check({tag, "_done_cycle"}, 64'(done_at), 64'd5);
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'd4);
        check({tag, "_result"}, result, er);
        check({tag, "_carry_out"}, {63'b0, carry_out}, {63'b0, ec});
        check({tag, "_overflow"}, {63'b0, overflow}, {63'b0, eo});
        @(negedge clk);
        check({tag, "_idle_after"}, {62'b0, busy, done}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; sub = 1'b0; op_a = 64'd7; op_b = 64'd9;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_busy_done", {62'b0, busy, done}, 64'd0);
            check("rst_result", result, 64'd0);
            check("rst_flags", {62'b0, carry_out, overflow}, 64'd0);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {62'b0, busy, done}, 64'd0);

        run_op("ripple", 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
               64'h0, 1'b1, 1'b0);
        run_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_op("borrow", 64'h0000_0000_0001_0000, 64'h0000_0000_0000_0001, 1'b1, 1'b0,
               64'h0000_0000_0000_FFFF, 1'b1, 1'b0);
        run_op("ignore", 64'd5, 64'd3, 1'b0, 1'b1, 64'd8, 1'b0, 1'b0);
        // back-to-back: issued in the first IDLE cycle after done
        run_op("b2b", 64'd10, 64'd20, 1'b0, 1'b0, 64'd30, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("hold_result", result, 64'd30);
        check("no_spurious", {62'b0, busy, done}, 64'd0);

        op_a = 64'hFFFF; op_b = 64'h1; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_result", result, 64'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            check("midrst_no_done", 64'(seen), 64'd0);
        end
        run_op("after_rst", 64'd1, 64'd1, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
